// File: rtl/conecta4_pkg.sv
// rtl/conecta4_pkg.sv - Connect-four cell/board types, scan directions and detector states
package conecta4_pkg;
    localparam int FILAS_DEF    = 6;
    localparam int COLS_DEF     = 7;
    localparam int EN_LINEA_DEF = 4;

    typedef logic [1:0] celda_t;
    localparam celda_t VACIA = 2'b00;
    localparam celda_t JUG1  = 2'b01;
    localparam celda_t JUG2  = 2'b10;

    typedef enum logic [1:0] {HORIZ, VERT, DIAG, ANTIDIAG} dir_t;
    typedef celda_t [FILAS_DEF-1:0][COLS_DEF-1:0] tablero_t;
    typedef enum logic [2:0] {IDLE, CAPTURA, ESCANEO, FIN, BLOQUEADO} estado_t;

    function automatic logic es_jugador(input celda_t c);
        return (c == JUG1) || (c == JUG2);
    endfunction
endpackage

// File: rtl/detector_ganador_if.sv
// rtl/detector_ganador_if.sv - Board/result bundle between drop block and winner detector
// Optional DETECTOR_MASCARA_EN adds the winning-line cell mask.
interface detector_ganador_if
    import conecta4_pkg::*;
#(
    parameter int FILAS    = FILAS_DEF,
    parameter int COLUMNAS = COLS_DEF
);
    logic                              inserted;
    logic [FILAS-1:0][COLUMNAS-1:0][1:0] tablero_in;
    logic                              busy;
    logic                              done;
    celda_t                            ganador;
    logic                              empate;
    logic                              juego_terminado;
`ifdef DETECTOR_MASCARA_EN
    logic [FILAS-1:0][COLUMNAS-1:0]    linea_ganadora;

    modport master (output inserted, tablero_in,
                    input  busy, done, ganador, empate, juego_terminado, linea_ganadora);
    modport slave  (input  inserted, tablero_in,
                    output busy, done, ganador, empate, juego_terminado, linea_ganadora);
`else
    modport master (output inserted, tablero_in,
                    input  busy, done, ganador, empate, juego_terminado);
    modport slave  (input  inserted, tablero_in,
                    output busy, done, ganador, empate, juego_terminado);
`endif
endinterface

// File: rtl/linea_check.sv
// rtl/linea_check.sv - Combinational test of one EN_LINEA line from a start cell and direction
// Optional DETECTOR_MASCARA_EN adds the matching-cell mask output.
module linea_check
    import conecta4_pkg::*;
#(
    parameter int FILAS    = FILAS_DEF,
    parameter int COLUMNAS = COLS_DEF,
    parameter int EN_LINEA = EN_LINEA_DEF,
    parameter int FW       = $clog2(FILAS),
    parameter int CW       = $clog2(COLUMNAS)
) (
    input  logic [FILAS-1:0][COLUMNAS-1:0][1:0] tablero_i,
    input  logic [FW-1:0]                       fila_i,
    input  logic [CW-1:0]                       col_i,
    input  dir_t                                dir_i,
    output logic                                match_o,
    output celda_t                              jugador_o
`ifdef DETECTOR_MASCARA_EN
    ,
    output logic [FILAS-1:0][COLUMNAS-1:0]      mascara_o
`endif
);
    logic   baja;
    logic   col_sube;
    logic   col_baja;
    logic   dentro;
    logic   iguales;
    celda_t primera;
    logic [FW-1:0] r;
    logic [CW-1:0] c;
`ifdef DETECTOR_MASCARA_EN
    logic [FILAS-1:0][COLUMNAS-1:0] mascara;
`endif

    assign baja     = (dir_i != HORIZ);
    assign col_sube = (dir_i == HORIZ) || (dir_i == DIAG);
    assign col_baja = (dir_i == ANTIDIAG);

    // Whole line must fit on the board before any cell is compared.
    assign dentro = (!baja     || (int'(fila_i) + EN_LINEA - 1 < FILAS)) &&
                    (!col_sube || (int'(col_i) + EN_LINEA - 1 < COLUMNAS)) &&
                    (!col_baja || (int'(col_i) >= EN_LINEA - 1));

    always_comb begin
        primera = tablero_i[fila_i][col_i];
        iguales = dentro && es_jugador(primera);
        r       = fila_i;
        c       = col_i;
`ifdef DETECTOR_MASCARA_EN
        mascara = '0;
`endif
        for (int i = 0; i < EN_LINEA; i++) begin
            r = baja ? fila_i + FW'(i) : fila_i;
            c = col_sube ? col_i + CW'(i) : (col_baja ? col_i - CW'(i) : col_i);
            if (dentro) begin
                if (tablero_i[r][c] != primera)
                    iguales = 1'b0;
`ifdef DETECTOR_MASCARA_EN
                mascara[r][c] = 1'b1;
`endif
            end
        end
    end

    assign match_o   = iguales;
    assign jugador_o = iguales ? primera : VACIA;
`ifdef DETECTOR_MASCARA_EN
    assign mascara_o = iguales ? mascara : '0;
`endif
endmodule

// File: rtl/detector_ganador.sv
// rtl/detector_ganador.sv - Snapshot-and-scan connect-four winner/draw detector
// Optional DETECTOR_MASCARA_EN exposes the winning-line mask.
module detector_ganador
    import conecta4_pkg::*;
#(
    parameter int FILAS    = FILAS_DEF,
    parameter int COLUMNAS = COLS_DEF,
    parameter int EN_LINEA = EN_LINEA_DEF
) (
    input  logic clk,
    input  logic reset,
    detector_ganador_if.slave bus
);
    localparam int         FW     = $clog2(FILAS);
    localparam int         CW     = $clog2(COLUMNAS);
    localparam logic [7:0] ULTIMO = 8'(FILAS * COLUMNAS * 4 - 1);

    typedef logic [FILAS-1:0][COLUMNAS-1:0][1:0] tab_t;

    estado_t       estado_q, estado_d;
    tab_t          snap_q, snap_d;
    logic [7:0]    idx_q, idx_d;
    logic [FW-1:0] fila_q, fila_d;
    logic [CW-1:0] col_q, col_d;
    dir_t          dir_q, dir_d;
    logic          pend_q, pend_d;
    celda_t        ganador_q, ganador_d;
    logic          empate_q, empate_d;
    logic          term_q, term_d;
    logic          hit;
    celda_t        jugador;
    logic          fila0_llena;
`ifdef DETECTOR_MASCARA_EN
    logic [FILAS-1:0][COLUMNAS-1:0] mask_q, mask_d, mask_lc;
`endif

    linea_check #(.FILAS(FILAS), .COLUMNAS(COLUMNAS), .EN_LINEA(EN_LINEA)) u_check (
        .tablero_i (snap_q),
        .fila_i    (fila_q),
        .col_i     (col_q),
        .dir_i     (dir_q),
`ifdef DETECTOR_MASCARA_EN
        .mascara_o (mask_lc),
`endif
        .match_o   (hit),
        .jugador_o (jugador)
    );

    // Gravity fills from the bottom, so a full top row means a full board.
    always_comb begin
        fila0_llena = 1'b1;
        for (int c = 0; c < COLUMNAS; c++)
            if (snap_q[0][c] == VACIA)
                fila0_llena = 1'b0;
    end

    always_comb begin
        estado_d  = estado_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        fila_d    = fila_q;
        col_d     = col_q;
        dir_d     = dir_q;
        pend_d    = pend_q;
        ganador_d = ganador_q;
        empate_d  = empate_q;
        term_d    = term_q;
`ifdef DETECTOR_MASCARA_EN
        mask_d    = mask_q;
`endif
        if (bus.inserted && (estado_q == CAPTURA || estado_q == ESCANEO))
            pend_d = 1'b1;
        case (estado_q)
            IDLE: if (bus.inserted && !term_q) estado_d = CAPTURA;
            CAPTURA: begin
                snap_d   = bus.tablero_in;
                idx_d    = '0;
                fila_d   = '0;
                col_d    = '0;
                dir_d    = HORIZ;
                estado_d = ESCANEO;
            end
            ESCANEO: begin
                if (hit) begin
                    ganador_d = jugador;
                    empate_d  = 1'b0;
                    term_d    = 1'b1;
`ifdef DETECTOR_MASCARA_EN
                    mask_d    = mask_lc;
`endif
                    estado_d  = FIN;
                end else if (idx_q == ULTIMO) begin
                    ganador_d = VACIA;
                    empate_d  = fila0_llena;
                    term_d    = fila0_llena;
`ifdef DETECTOR_MASCARA_EN
                    mask_d    = '0;
`endif
                    estado_d  = FIN;
                end else begin
                    idx_d = idx_q + 8'd1;
                    dir_d = dir_t'(dir_q + 2'd1);
                    if (dir_q == ANTIDIAG) begin
                        if (col_q == CW'(COLUMNAS - 1)) begin
                            col_d  = '0;
                            fila_d = fila_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            FIN: begin
                pend_d = 1'b0;
                if (term_q)
                    estado_d = BLOQUEADO;
                else if (pend_q || bus.inserted)
                    estado_d = CAPTURA;
                else
                    estado_d = IDLE;
            end
            default: estado_d = estado_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q  <= IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            fila_q    <= '0;
            col_q     <= '0;
            dir_q     <= HORIZ;
            pend_q    <= 1'b0;
            ganador_q <= VACIA;
            empate_q  <= 1'b0;
            term_q    <= 1'b0;
`ifdef DETECTOR_MASCARA_EN
            mask_q    <= '0;
`endif
        end else begin
            estado_q  <= estado_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            fila_q    <= fila_d;
            col_q     <= col_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            ganador_q <= ganador_d;
            empate_q  <= empate_d;
            term_q    <= term_d;
`ifdef DETECTOR_MASCARA_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign bus.busy            = (estado_q == CAPTURA) || (estado_q == ESCANEO) || (estado_q == FIN);
    assign bus.done            = (estado_q == FIN);
    assign bus.ganador         = ganador_q;
    assign bus.empate          = empate_q;
    assign bus.juego_terminado = term_q;
`ifdef DETECTOR_MASCARA_EN
    assign bus.linea_ganadora  = mask_q;
`endif
endmodule

// File: doc/detector_ganador.md
Name: detector_ganador

Overview:
Reader side of the board interface written by the token-drop block. On each `inserted` pulse it snapshots the board and scans every 4-in-a-row line sequentially, one line per cycle. It reports the winner, a draw and a sticky `juego_terminado`. That flag feeds back to the drop block to freeze play, and also feeds the display/VGA logic.

Parameters:
FILAS, 6, board rows; row 0 is the top row and row FILAS-1 is the bottom (fill) row.
COLUMNAS, 7, board columns.
EN_LINEA, 4, consecutive equal tokens required to win.

Ports:
clk  input  1  system clock (25 MHz).
reset  input  1  asynchronous, active-low reset (0 = reset).
inserted  input  1  one-cycle pulse: a token was just written to the board.
tablero_in  input  2 x [FILAS][COLUMNAS]  board; 00 empty, 01 player 1, 10 player 2, 11 invalid.
busy  output  1  high while a snapshot or scan is in progress.
done  output  1  one-cycle pulse when a scan completes.
ganador  output  2  01/10 = winning player; 00 = none.
empate  output  1  board full with no winner.
juego_terminado  output  1  ganador != 00 or empate; sticky.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy=0, done=0, ganador=00, empate=0, juego_terminado=0, pending flag cleared, snapshot cleared. Reset asserted mid-scan aborts the scan with no done pulse.
- States: IDLE, CAPTURA, ESCANEO, FIN, BLOQUEADO.
- IDLE: `inserted`=1 and juego_terminado=0 -> CAPTURA.
- CAPTURA: lasts 1 cycle. Latches tablero_in into the snapshot and clears the index -> ESCANEO.
- ESCANEO: evaluates one (row, col, dir) per cycle from the snapshot only; later tablero_in changes are ignored.
  - Order: row 0..FILAS-1 outer, col 0..COLUMNAS-1, dir inner. Dir 0 = horizontal (r, c+i); 1 = vertical (r+i, c); 2 = diagonal (r+i, c+i); 3 = anti-diagonal (r+i, c-i); i = 0..EN_LINEA-1.
  - A line that leaves the board is a no-match but still consumes its cycle.
  - Match: all EN_LINEA cells equal and either 01 or 10. Cells with 00 or 11 never match.
  - First match wins: latch ganador from the start cell -> FIN.
  - Index reaching FILAS*COLUMNAS*4 (168 by default) with no match -> FIN. In that case empate=1 iff every row-0 cell of the snapshot is nonzero.
- FIN: lasts 1 cycle. done=1.
  - juego_terminado set -> BLOQUEADO.
  - else pending set -> clear pending, -> CAPTURA.
  - else -> IDLE.
- BLOQUEADO: terminal. Ignores `inserted`; all outputs hold until reset.
- Timing: `inserted` high in cycle t gives CAPTURA at t+1 and check k in cycle t+2+k.
  - Hit at check k: done and results valid at t+3+k.
  - No hit: done at t+170.
  - busy is high from t+1 through the done cycle inclusive.
- `inserted` while busy: sets pending; multiple pulses collapse into one rescan.
- `inserted` coincident with FIN: counts as pending.
- ganador and empate update only in the done cycle, hold between scans, and are mutually exclusive.
- Index counter is 8 bits and never wraps; it terminates at the limit.

Optional Feature:
DETECTOR_MASCARA_EN.
- Defined: adds output `linea_ganadora` (1 x [FILAS][COLUMNAS]).
  - In the done cycle of a win, exactly the EN_LINEA cells of the first matching line are 1; all others are 0.
  - Cleared at reset; held in BLOQUEADO.
  - All-zero on a draw.
- Undefined: port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package conecta4_pkg:
  - celda_t (2-bit), constants VACIA=00, JUG1=01, JUG2=10.
  - FILAS_DEF=6, COLS_DEF=7.
  - dir_t enum {HORIZ, VERT, DIAG, ANTIDIAG}.
  - tablero_t typedef.
- Sub-module linea_check (combinational): inputs snapshot, row, col, dir; outputs match, player and the optional cell mask. It includes the bounds check.

Test Plan:
1. Row 5 cols 0-3 = 01, pulse `inserted` at t -> ganador=01, done at t+3+k with k=(5*7+0)*4+0=140 (t+143), juego_terminado=1.
2. Col 6 rows 2-5 = 10 -> ganador=10 (vertical, start row 2). Further `inserted` pulses produce no busy and no done.
3. Anti-diagonal (2,3),(3,2),(4,1),(5,0) = 01 -> ganador=01. With DETECTOR_MASCARA_EN, exactly those four mask bits are 1.
4. Sparse board with no line and a free top cell -> done at t+170, ganador=00, empate=0, state returns to IDLE.
5. Full alternating board with no line -> done at t+170, empate=1, juego_terminado=1. A line of 11 cells never reports a win.
6. Two `inserted` pulses during a scan -> exactly one rescan follows the first done. Reset=0 pulsed mid-scan -> all outputs 0 immediately, no done pulse.
